// File: rtl/mem_wb_skid_pipe_if.sv
// ============================================================================
// Module      : mem_wb_skid_pipe_if
// Description : MEM->WB handshake bundle: upstream in_* side, downstream out_* side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_wb_skid_pipe_if #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3
) ();
    logic               in_valid;
    logic               in_ready;
    logic               in_flush;
    logic [DATA_W-1:0]  in_mem_out;
    logic [DATA_W-1:0]  in_pc_plus2;
    logic [DATA_W-1:0]  in_x_out;
    logic [RADDR_W-1:0] in_wr_reg;
    logic               in_mem_to_reg;
    logic               in_reg_write;
    logic               in_link;
    logic               in_halt;

    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_mem_out;
    logic [DATA_W-1:0]  out_pc_plus2;
    logic [DATA_W-1:0]  out_x_out;
    logic [RADDR_W-1:0] out_wr_reg;
    logic               out_mem_to_reg;
    logic               out_reg_write;
    logic               out_link;
    logic               out_halt;
    logic               halt_done;

    // Pipeline register view.
    modport slave (
        input  in_valid, in_flush, in_mem_out, in_pc_plus2, in_x_out, in_wr_reg,
               in_mem_to_reg, in_reg_write, in_link, in_halt, out_ready,
        output in_ready, out_valid, out_mem_out, out_pc_plus2, out_x_out, out_wr_reg,
               out_mem_to_reg, out_reg_write, out_link, out_halt, halt_done
    );

    // Surrounding pipeline (MEM producer + WB consumer) view.
    modport master (
        output in_valid, in_flush, in_mem_out, in_pc_plus2, in_x_out, in_wr_reg,
               in_mem_to_reg, in_reg_write, in_link, in_halt, out_ready,
        input  in_ready, out_valid, out_mem_out, out_pc_plus2, out_x_out, out_wr_reg,
               out_mem_to_reg, out_reg_write, out_link, out_halt, halt_done
    );
endinterface

`default_nettype wire

// File: rtl/mem_wb_skid_pipe.sv
// ============================================================================
// Module      : mem_wb_skid_pipe
// Description : MEM/WB pipeline register with 2-entry skid buffer, flush and
//               sticky halt tracking. Optional WB_FWD_EN adds a bypass port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_skid_pipe #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3
) (
    input  wire logic            clk,
    input  wire logic            rst,
    mem_wb_skid_pipe_if.slave    bus
`ifdef WB_FWD_EN
    ,
    output logic                 fwd_valid,
    output logic [RADDR_W-1:0]   fwd_reg,
    output logic [DATA_W-1:0]    fwd_data
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0]  mem_out;
        logic [DATA_W-1:0]  pc_plus2;
        logic [DATA_W-1:0]  x_out;
        logic [RADDR_W-1:0] wr_reg;
        logic               mem_to_reg;
        logic               reg_write;
        logic               link;
        logic               halt;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_v_q, main_v_d;
    logic   skid_v_q, skid_v_d;
    logic   halt_done_q, halt_done_d;

    entry_t in_ent;
    logic   in_ready;
    logic   accept;
    logic   retire;

    always_comb begin
        in_ent            = '0;
        in_ent.mem_out    = bus.in_mem_out;
        in_ent.pc_plus2   = bus.in_pc_plus2;
        in_ent.x_out      = bus.in_x_out;
        in_ent.wr_reg     = bus.in_wr_reg;
        in_ent.mem_to_reg = bus.in_mem_to_reg;
        in_ent.reg_write  = bus.in_reg_write;
        in_ent.link       = bus.in_link;
        in_ent.halt       = bus.in_halt;
    end

    // Ready depends only on registered state, so WB stalls never ripple into MEM combinationally.
    assign in_ready = ~skid_v_q & ~halt_done_q;
    assign accept   = bus.in_valid & in_ready;
    assign retire   = main_v_q & bus.out_ready;

    always_comb begin
        main_d      = main_q;
        skid_d      = skid_q;
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        halt_done_d = halt_done_q | (retire & main_q.halt);

        if (bus.in_flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (retire) begin
            if (skid_v_q) begin
                // accept is impossible here: in_ready is low whenever the skid is occupied.
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end else if (accept) begin
                main_d   = in_ent;
                main_v_d = 1'b1;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (accept) begin
            if (main_v_q) begin
                skid_d   = in_ent;
                skid_v_d = 1'b1;
            end else begin
                main_d   = in_ent;
                main_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q      <= '0;
            skid_q      <= '0;
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            halt_done_q <= 1'b0;
        end else begin
            main_q      <= main_d;
            skid_q      <= skid_d;
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            halt_done_q <= halt_done_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = main_v_q;
    assign bus.out_mem_out    = main_q.mem_out;
    assign bus.out_pc_plus2   = main_q.pc_plus2;
    assign bus.out_x_out      = main_q.x_out;
    assign bus.out_wr_reg     = main_q.wr_reg;
    assign bus.out_mem_to_reg = main_q.mem_to_reg;
    assign bus.out_reg_write  = main_q.reg_write;
    assign bus.out_link       = main_q.link;
    assign bus.out_halt       = main_q.halt;
    assign bus.halt_done      = halt_done_q;

`ifdef WB_FWD_EN
    // Same selection the WB stage applies, taken straight off the head register.
    assign fwd_valid = main_v_q & main_q.reg_write;
    assign fwd_reg   = main_q.wr_reg;
    assign fwd_data  = main_q.link       ? main_q.pc_plus2 :
                       main_q.mem_to_reg ? main_q.mem_out  : main_q.x_out;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_skid_pipe.sv
// ============================================================================
// Module      : tb_mem_wb_skid_pipe
// Description : Self-checking bench for mem_wb_skid_pipe (FIFO model + directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_skid_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] mem_out;
        logic [15:0] pc_plus2;
        logic [15:0] x_out;
        logic [2:0]  wr_reg;
        logic        mem_to_reg;
        logic        reg_write;
        logic        link;
        logic        halt;
    } ent_t;

    mem_wb_skid_pipe_if #(.DATA_W(16), .RADDR_W(3)) bus ();

`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [2:0]  fwd_reg;
    logic [15:0] fwd_data;
`endif

    mem_wb_skid_pipe #(.DATA_W(16), .RADDR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef WB_FWD_EN
        ,
        .fwd_valid (fwd_valid),
        .fwd_reg   (fwd_reg),
        .fwd_data  (fwd_data)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of held entries, occupancy capped at two.
    ent_t q[$];
    bit   hd   = 1'b0;
    bit   live = 1'b0;
    int   retire_cnt = 0;

    function automatic ent_t cur_in();
        ent_t e;
        e = {bus.in_mem_out, bus.in_pc_plus2, bus.in_x_out, bus.in_wr_reg,
             bus.in_mem_to_reg, bus.in_reg_write, bus.in_link, bus.in_halt};
        return e;
    endfunction

    function automatic ent_t dut_head();
        ent_t e;
        e = {bus.out_mem_out, bus.out_pc_plus2, bus.out_x_out, bus.out_wr_reg,
             bus.out_mem_to_reg, bus.out_reg_write, bus.out_link, bus.out_halt};
        return e;
    endfunction

    always @(posedge clk) begin : model
        bit acc;
        bit ret;
        if (rst) begin
            q.delete();
            hd   = 1'b0;
            live = 1'b1;
        end else if (live) begin
            acc = bus.in_valid && (q.size() < 2) && !hd;
            ret = (q.size() > 0) && bus.out_ready;
            if (ret) begin
                if (q[0].halt) hd = 1'b1;
                void'(q.pop_front());
                retire_cnt++;
            end
            if (bus.in_flush) q.delete();
            else if (acc) q.push_back(cur_in());
        end
    end

    always @(negedge clk) begin : compare
        if (live) begin
            chk("m_out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
            chk("m_in_ready",  64'(bus.in_ready),  64'((q.size() < 2) && !hd));
            chk("m_halt_done", 64'(bus.halt_done), 64'(hd));
            if (q.size() > 0) chk("m_head", 64'(dut_head()), 64'(q[0]));
`ifdef WB_FWD_EN
            if (q.size() > 0) begin
                chk("m_fwd_valid", 64'(fwd_valid), 64'(q[0].reg_write));
                chk("m_fwd_reg",   64'(fwd_reg),   64'(q[0].wr_reg));
                chk("m_fwd_data",  64'(fwd_data),
                    64'(q[0].link ? q[0].pc_plus2 : q[0].mem_to_reg ? q[0].mem_out : q[0].x_out));
            end else begin
                chk("m_fwd_valid", 64'(fwd_valid), 64'd0);
            end
`endif
        end
    end

    task automatic drive(input bit v, input logic [15:0] x, input bit halt = 1'b0);
        bus.in_valid      = v;
        bus.in_x_out      = x;
        bus.in_mem_out    = x ^ 16'hA5A5;
        bus.in_pc_plus2   = x + 16'd2;
        bus.in_wr_reg     = x[2:0];
        bus.in_mem_to_reg = x[0];
        bus.in_reg_write  = 1'b1;
        bus.in_link       = 1'b0;
        bus.in_halt       = halt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int rc0;
        rst           = 1'b1;
        bus.in_flush  = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 16'd0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_x_out",     64'(bus.out_x_out), 64'd0);
        chk("rst_halt_done", 64'(bus.halt_done), 64'd0);
        rst = 1'b0;

        // Streaming at full rate, latency 1.
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 16'(k));
            @(negedge clk);
            chk("t1_x_out",     64'(bus.out_x_out), 64'(k));
            chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
            chk("t1_in_ready",  64'(bus.in_ready),  64'd1);
        end
        drive(1'b0, 16'd0);
        @(negedge clk);
        chk("t1_drain", 64'(bus.out_valid), 64'd0);

        // Back-pressure fills the skid, then drains in order.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'd5);
        @(negedge clk);
        chk("t2_ready_one", 64'(bus.in_ready), 64'd1);
        drive(1'b1, 16'd6);
        @(negedge clk);
        chk("t2_ready_full", 64'(bus.in_ready), 64'd0);
        drive(1'b1, 16'd7);
        @(negedge clk);
        chk("t2_hold5", 64'(bus.out_x_out), 64'd5);
        rc0 = retire_cnt;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t2_x6", 64'(bus.out_x_out), 64'd6);
        @(negedge clk);
        chk("t2_x7", 64'(bus.out_x_out), 64'd7);
        drive(1'b0, 16'd0);
        @(negedge clk);
        chk("t2_empty",   64'(bus.out_valid), 64'd0);
        chk("t2_retires", 64'(retire_cnt - rc0), 64'd3);

        // Flush with two held entries and a retiring head.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'd10);
        @(negedge clk);
        drive(1'b1, 16'd11);
        @(negedge clk);
        drive(1'b1, 16'd12);
        bus.in_flush  = 1'b1;
        bus.out_ready = 1'b1;
        rc0 = retire_cnt;
        @(negedge clk);
        bus.in_flush = 1'b0;
        drive(1'b0, 16'd0);
        chk("t3_flushed",   64'(bus.out_valid), 64'd0);
        chk("t3_retire1",   64'(retire_cnt - rc0), 64'd1);
        @(negedge clk);
        chk("t3_no_ghost",  64'(bus.out_valid), 64'd0);

        // Flush while an input would otherwise be accepted.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'd13);
        @(negedge clk);
        drive(1'b1, 16'd14);
        bus.in_flush = 1'b1;
        @(negedge clk);
        bus.in_flush = 1'b0;
        drive(1'b0, 16'd0);
        chk("t3b_flushed", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t3b_dropped", 64'(bus.out_valid), 64'd0);

`ifdef WB_FWD_EN
        // Bypass port selection.
        bus.out_ready     = 1'b0;
        bus.in_valid      = 1'b1;
        bus.in_link       = 1'b1;
        bus.in_mem_to_reg = 1'b0;
        bus.in_pc_plus2   = 16'h0042;
        bus.in_mem_out    = 16'h2222;
        bus.in_x_out      = 16'h1111;
        bus.in_wr_reg     = 3'd7;
        bus.in_reg_write  = 1'b1;
        bus.in_halt       = 1'b0;
        @(negedge clk);
        chk("t5_fwd_valid", 64'(fwd_valid), 64'd1);
        chk("t5_fwd_reg",   64'(fwd_reg),   64'd7);
        chk("t5_fwd_link",  64'(fwd_data),  64'h0042);
        bus.out_ready     = 1'b1;
        bus.in_link       = 1'b0;
        bus.in_mem_to_reg = 1'b1;
        bus.in_mem_out    = 16'hBEEF;
        @(negedge clk);
        chk("t5_fwd_mem",   64'(fwd_data),  64'hBEEF);
        drive(1'b0, 16'd0);
        @(negedge clk);
        chk("t5_fwd_idle",  64'(fwd_valid), 64'd0);
`endif

        // Halt retirement blocks further accepts until reset.
        bus.out_ready = 1'b1;
        drive(1'b1, 16'd8, 1'b1);
        @(negedge clk);
        chk("t4_head_halt", 64'(bus.out_halt), 64'd1);
        drive(1'b1, 16'd9);
        @(negedge clk);
        chk("t4_halt_done", 64'(bus.halt_done), 64'd1);
        chk("t4_in_ready",  64'(bus.in_ready),  64'd0);
        chk("t4_x9",        64'(bus.out_x_out), 64'd9);
        drive(1'b1, 16'd10);
        @(negedge clk);
        chk("t4_drained", 64'(bus.out_valid), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t4_blocked", 64'(bus.out_valid), 64'd0);
        end
        rst = 1'b1;
        drive(1'b0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("t4_rst_hd",    64'(bus.halt_done), 64'd0);
        chk("t4_rst_ready", 64'(bus.in_ready),  64'd1);

        // Reset with two entries held.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'd20);
        @(negedge clk);
        drive(1'b1, 16'd21);
        @(negedge clk);
        drive(1'b0, 16'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_valid", 64'(bus.out_valid),    64'd0);
        chk("t6_x",     64'(bus.out_x_out),    64'd0);
        chk("t6_pc",    64'(bus.out_pc_plus2), 64'd0);
        chk("t6_mem",   64'(bus.out_mem_out),  64'd0);
        chk("t6_wr",    64'(bus.out_wr_reg),   64'd0);
        chk("t6_hd",    64'(bus.halt_done),    64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_ready", 64'(bus.in_ready), 64'd1);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
